// File: rtl/transposed_fir_rnd_pkg.sv
// Shared width arithmetic and saturation limits for the transposed FIR and
// its rounding/saturation stage.
package transposed_fir_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  function automatic int prod_width(input int data_w, input int coeff_w);
    return data_w + coeff_w;
  endfunction

  // Log2 headroom on top of the product keeps the whole tap chain overflow-free.
  function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
    return data_w + coeff_w + clog2(taps);
  endfunction

  function automatic logic signed [63:0] sat_max(input int out_w);
    return (64'sd1 <<< (out_w - 32'sd1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int out_w);
    return -(64'sd1 <<< (out_w - 32'sd1));
  endfunction

endpackage

// File: rtl/transposed_fir_rnd_round_sym_sat.sv
// Registered round-half-away-from-zero and saturate stage with valid
// passthrough; Data_o/Sat_o hold between valids.
module round_sym_sat
  import transposed_fir_pkg::*;
#(
  parameter int InWidth    = 40,
  parameter int RoundShift = 20,
  parameter int OutWidth   = 18
) (
  input  logic                       Clk_i,
  input  logic                       Rst_i,
  input  logic                       Flush_i,
  input  logic signed [InWidth-1:0]  Data_i,
  input  logic                       Valid_i,
  output logic signed [OutWidth-1:0] Data_o,
  output logic                       Valid_o,
  output logic                       Sat_o
);

  localparam int SumWidth = InWidth + 32'sd1;

  logic        [SumWidth-1:0] w_ext;
  logic signed [SumWidth-1:0] w_sum;
  logic signed [SumWidth-1:0] w_rnd;
  logic signed [63:0]         w_rnd64;
  logic signed [63:0]         w_max64;
  logic signed [63:0]         w_min64;
  logic signed [OutWidth-1:0] w_out;
  logic                       w_sat;

  logic signed [OutWidth-1:0] r_data;
  logic                       r_valid;
  logic                       r_sat;

  assign w_ext = {Data_i[InWidth-1], Data_i};

  generate
    if (RoundShift > 0) begin : g_round
      localparam logic [SumWidth-1:0] One  = {{(SumWidth-1){1'b0}}, 1'b1};
      localparam logic [SumWidth-1:0] Half = One << (RoundShift - 32'sd1);

      // Negative inputs get half-minus-one so that exact halves move away from zero.
      always_comb begin
        if (Data_i[InWidth-1]) begin
          w_sum = w_ext + Half - One;
        end else begin
          w_sum = w_ext + Half;
        end
      end
    end else begin : g_pass
      assign w_sum = w_ext;
    end
  endgenerate

  assign w_rnd = w_sum >>> RoundShift;

  // Clamp the rounded value into the signed output range.
  always_comb begin
    w_rnd64 = {{(64-SumWidth){w_rnd[SumWidth-1]}}, w_rnd};
    w_max64 = sat_max(OutWidth);
    w_min64 = sat_min(OutWidth);
    if (w_rnd64 > w_max64) begin
      w_out = w_max64[OutWidth-1:0];
      w_sat = 1'b1;
    end else if (w_rnd64 < w_min64) begin
      w_out = w_min64[OutWidth-1:0];
      w_sat = 1'b1;
    end else begin
      w_out = w_rnd64[OutWidth-1:0];
      w_sat = 1'b0;
    end
  end

  // Output register: loads only on a valid input, clears valid/sat on flush.
  always_ff @(posedge Clk_i) begin
    if (!Rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else if (Flush_i) begin
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_valid <= Valid_i;
      if (Valid_i) begin
        r_data <= w_out;
        r_sat  <= w_sat;
      end
    end
  end

  assign Data_o  = r_data;
  assign Valid_o = r_valid;
  assign Sat_o   = r_sat;

endmodule

// File: rtl/transposed_fir_rnd.sv
// Transposed-form FIR with a writable coefficient file, feeding the shared
// round/saturate stage. Two-register latency from strobe to DataValid_o.
module transposed_fir_rnd
  import transposed_fir_pkg::*;
#(
  parameter int DataWidth  = 18,
  parameter int CoeffWidth = 18,
  parameter int CoeffCount = 16,
  parameter int RoundShift = 20,
  parameter int OutWidth   = 18
) (
  input  logic                           Clk_i,
  input  logic                           Rst_i,
  input  logic signed [DataWidth-1:0]    Data_i,
  input  logic                           DataNd_i,
  input  logic                           Flush_i,
  input  logic                           CoeffWe_i,
  input  logic [clog2(CoeffCount)-1:0]   CoeffAddr_i,
  input  logic signed [CoeffWidth-1:0]   CoeffData_i,
  output logic signed [OutWidth-1:0]     Data_o,
  output logic                           DataValid_o,
  output logic                           Sat_o
);

  localparam int ProdWidth = prod_width(DataWidth, CoeffWidth);
  localparam int AccWidth  = acc_width(DataWidth, CoeffWidth, CoeffCount);
  localparam int AddrWidth = clog2(CoeffCount);

  logic signed [CoeffWidth-1:0] r_coeff [CoeffCount];
  logic signed [AccWidth-1:0]   r_acc   [1:CoeffCount-1];
  logic signed [AccWidth-1:0]   r_y;
  logic                         r_y_vld;

  logic        [ProdWidth-1:0]  w_mul   [CoeffCount];
  logic signed [AccWidth-1:0]   w_prod  [CoeffCount];

  // Sign-extend both operands to the product width so the low bits are the signed product.
  always_comb begin
    for (int k = 0; k < CoeffCount; k++) begin
      w_mul[k]  = {{CoeffWidth{Data_i[DataWidth-1]}}, Data_i}
                * {{DataWidth{r_coeff[k][CoeffWidth-1]}}, r_coeff[k]};
      w_prod[k] = {{(AccWidth-ProdWidth){w_mul[k][ProdWidth-1]}}, w_mul[k]};
    end
  end

  // Coefficient file; addresses beyond the last tap match no entry and are dropped.
  always_ff @(posedge Clk_i) begin
    if (!Rst_i) begin
      for (int k = 0; k < CoeffCount; k++) begin
        r_coeff[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CoeffCount; k++) begin
        if (CoeffWe_i && (CoeffAddr_i == AddrWidth'(k))) begin
          r_coeff[k] <= CoeffData_i;
        end
      end
    end
  end

  // Tap chain and stage-1 result; advances only on an accepted sample.
  always_ff @(posedge Clk_i) begin
    if (!Rst_i) begin
      for (int k = 1; k < CoeffCount; k++) begin
        r_acc[k] <= '0;
      end
      r_y     <= '0;
      r_y_vld <= 1'b0;
    end else if (Flush_i) begin
      for (int k = 1; k < CoeffCount; k++) begin
        r_acc[k] <= '0;
      end
      r_y_vld <= 1'b0;
    end else begin
      r_y_vld <= DataNd_i;
      if (DataNd_i) begin
        for (int k = 1; k < CoeffCount - 32'sd1; k++) begin
          r_acc[k] <= w_prod[k] + r_acc[k+1];
        end
        r_acc[CoeffCount-1] <= w_prod[CoeffCount-1];
        r_y                 <= w_prod[0] + r_acc[1];
      end
    end
  end

  round_sym_sat #(
    .InWidth   (AccWidth),
    .RoundShift(RoundShift),
    .OutWidth  (OutWidth)
  ) u_round (
    .Clk_i  (Clk_i),
    .Rst_i  (Rst_i),
    .Flush_i(Flush_i),
    .Data_i (r_y),
    .Valid_i(r_y_vld),
    .Data_o (Data_o),
    .Valid_o(DataValid_o),
    .Sat_o  (Sat_o)
  );

endmodule
